// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every handshake and data signal around the shared memory port:
// the I-cache refill channel, the D-cache refill/write-back channel and
// the single off-chip memory channel.
//   slave  modport : the arbiter's view (requests and mem_rdata/mem_ready in,
//                    readies, line data and memory strobes out).
//   master modport : the environment's view (caches plus memory model).
// Parameters: ADDR_W line address width, DATA_W line width in bits.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);

  // I-cache channel (read-only refills)
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  // D-cache channel (refills and dirty write-backs)
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  // Shared memory channel
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the one off-chip memory port between the I-cache (line refills)
// and the D-cache (line refills and write-backs). One line transaction is
// in flight at a time; ties are broken round-robin so neither cache can
// starve the other. Completion (ready) and read data are steered back to
// whichever cache owns the current transaction.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave carrying the I-cache, D-cache and memory
//            channels (requests/addresses/write data in, readies/read data
//            and registered memory strobes/address/write data out)
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arbState;

  arbState           r_state;
  logic              r_lastGrantD;
  logic              r_memRead;
  logic              r_memWrite;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;

  logic              w_reqI;
  logic              w_reqD;
  logic              w_pickI;

  // Request decode and the round-robin choice. The I side wins when it is
  // the only requester, or when both ask and D was served last time.
  assign w_reqI  = bus.i_read;
  assign w_reqD  = bus.d_read | bus.d_write;
  assign w_pickI = w_reqI & (~w_reqD | r_lastGrantD);

  // Single sequencer for the shared port. Address, data and direction are
  // captured only on the IDLE->grant edge, so requester inputs moving during
  // a grant never reach memory. On mem_ready the strobes drop on the same
  // edge that returns to IDLE, which forces a strobe-low cycle between
  // transactions. Reset clears last grant to I so the first tie goes to D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lastGrantD <= 1'b0;
      r_memRead    <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickI) begin
            r_state    <= GNT_I;
            r_memRead  <= 1'b1;
            r_memWrite <= 1'b0;
            r_memAddr  <= bus.i_addr;
          end else if (w_reqD) begin
            r_state    <= GNT_D;
            r_memRead  <= bus.d_read;
            r_memWrite <= bus.d_write;
            r_memAddr  <= bus.d_addr;
            r_memWdata <= bus.d_wdata;
          end
        end
        GNT_I: begin
          if (bus.mem_ready) begin
            r_state      <= IDLE;
            r_lastGrantD <= 1'b0;
            r_memRead    <= 1'b0;
            r_memWrite   <= 1'b0;
          end
        end
        GNT_D: begin
          if (bus.mem_ready) begin
            r_state      <= IDLE;
            r_lastGrantD <= 1'b1;
            r_memRead    <= 1'b0;
            r_memWrite   <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_memRead  <= 1'b0;
          r_memWrite <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side outputs come straight from the registers above.
  assign bus.mem_read  = r_memRead;
  assign bus.mem_write = r_memWrite;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

  // Completion is combinational so the owning cache sees ready in the same
  // cycle memory does. Line data is simply fanned out to both caches; each
  // only looks at it while its own ready is high.
  assign bus.i_ready = (r_state == GNT_I) & bus.mem_ready;
  assign bus.d_ready = (r_state == GNT_D) & bus.mem_ready;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized two-requester run checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Quiesce all requesters and pulse reset.
  task automatic do_reset();
    bus.i_read = 0; bus.d_read = 0; bus.d_write = 0; bus.mem_ready = 0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.mem_ready = 1;
    step();
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_read: got %0b want 0", bus.mem_read); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset mem_write: got %0b want 0", bus.mem_write); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("[TB] FAIL reset mem_addr: got %0h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset mem_wdata: got %0h want 0", bus.mem_wdata); end
    checks++; if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset readies: got i=%0b d=%0b want 0/0", bus.i_ready, bus.d_ready); end
    bus.mem_ready = 0;
    rst_n = 1;
    step();
  endtask

  task automatic test_single_i_read();
    logic [DATA_W-1:0] pat;
    pat = {4{32'hDEADBEEF}};
    bus.i_read = 1; bus.i_addr = 28'h0000010;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL single_i strobes: got r=%0b w=%0b want 1/0", bus.mem_read, bus.mem_write); end
    checks++; if (bus.mem_addr !== 28'h0000010) begin errors++; $display("[TB] FAIL single_i mem_addr: got %0h want 10", bus.mem_addr); end
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.i_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_i hold: got r=%0b iready=%0b want 1/0", bus.mem_read, bus.i_ready); end
    bus.mem_rdata = pat; bus.mem_ready = 1;
    #1;
    checks++; if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_i ready: got i=%0b d=%0b want 1/0", bus.i_ready, bus.d_ready); end
    checks++; if (bus.i_rdata !== pat) begin errors++; $display("[TB] FAIL single_i rdata: got %0h want %0h", bus.i_rdata, pat); end
    step();
    bus.i_read = 0; bus.mem_ready = 0;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL single_i strobe_low: got %0b want 0", bus.mem_read); end
    step();
  endtask

  task automatic test_d_write();
    logic [DATA_W-1:0] wd;
    wd = {32{4'h1}};
    bus.d_write = 1; bus.d_addr = 28'h0000ABC; bus.d_wdata = wd;
    step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL d_write strobes[%0d]: got r=%0b w=%0b want 0/1", k, bus.mem_read, bus.mem_write); end
      checks++; if (bus.mem_addr !== 28'h0000ABC || bus.mem_wdata !== wd) begin errors++; $display("[TB] FAIL d_write payload[%0d]: got %0h/%0h want abc/%0h", k, bus.mem_addr, bus.mem_wdata, wd); end
      checks++; if (bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL d_write early_ready[%0d]: got %0b want 0", k, bus.d_ready); end
      step();
    end
    bus.mem_ready = 1;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin errors++; $display("[TB] FAIL d_write ready: got d=%0b i=%0b want 1/0", bus.d_ready, bus.i_ready); end
    step();
    bus.d_write = 0; bus.mem_ready = 0;
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL d_write strobe_low: got %0b want 0", bus.mem_write); end
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.i_read = 1; bus.i_addr = 28'h0000123;
    bus.d_read = 1; bus.d_addr = 28'h0000456;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000456) begin errors++; $display("[TB] FAIL simul first_d: got r=%0b addr=%0h want 1/456", bus.mem_read, bus.mem_addr); end
    step();
    bus.mem_rdata = {4{32'h0D0D0D0D}}; bus.mem_ready = 1;
    #1;
    checks++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin errors++; $display("[TB] FAIL simul d_ready: got d=%0b i=%0b want 1/0", bus.d_ready, bus.i_ready); end
    step();
    bus.d_read = 0; bus.mem_ready = 0;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL simul gap: got %0b want 0", bus.mem_read); end
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000123) begin errors++; $display("[TB] FAIL simul then_i: got r=%0b addr=%0h want 1/123", bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1;
    #1;
    checks++; if (bus.i_ready !== 1'b1 || bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL simul i_ready: got i=%0b d=%0b want 1/0", bus.i_ready, bus.d_ready); end
    step();
    bus.i_read = 0; bus.mem_ready = 0;
    step();
  endtask

  // Last grant was I, so with both sides always asking the order is D,I,D,I...
  task automatic test_alternation();
    bit expD;
    bus.i_read = 1; bus.i_addr = 28'h0001000;
    bus.d_read = 1; bus.d_addr = 28'h0002000;
    for (int k = 0; k < 6; k++) begin
      expD = (k % 2 == 0);
      for (int w = 0; w < 4 && bus.mem_read !== 1'b1; w++) step();
      checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== (expD ? 28'h0002000 : 28'h0001000)) begin errors++; $display("[TB] FAIL alt grant[%0d]: got r=%0b addr=%0h want 1/%0h", k, bus.mem_read, bus.mem_addr, expD ? 28'h0002000 : 28'h0001000); end
      bus.mem_rdata = {4{k}}; bus.mem_ready = 1;
      #1;
      checks++; if (bus.d_ready !== expD || bus.i_ready !== !expD) begin errors++; $display("[TB] FAIL alt ready[%0d]: got d=%0b i=%0b want %0b/%0b", k, bus.d_ready, bus.i_ready, expD, !expD); end
      step();
      bus.mem_ready = 0;
    end
    bus.i_read = 0; bus.d_read = 0;
    step();
  endtask

  task automatic test_stability();
    bus.d_read = 1; bus.d_addr = 28'h00000AA;
    step();
    checks++; if (bus.mem_addr !== 28'h00000AA) begin errors++; $display("[TB] FAIL stab latch: got %0h want aa", bus.mem_addr); end
    bus.d_addr = 28'h00000BB;
    step();
    checks++; if (bus.mem_addr !== 28'h00000AA || bus.mem_read !== 1'b1) begin errors++; $display("[TB] FAIL stab held: got addr=%0h r=%0b want aa/1", bus.mem_addr, bus.mem_read); end
    bus.mem_ready = 1;
    #1;
    checks++; if (bus.d_ready !== 1'b1) begin errors++; $display("[TB] FAIL stab d_ready: got %0b want 1", bus.d_ready); end
    step();
    bus.d_read = 0;
    #1;
    checks++; if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL stab idle_ready: got i=%0b d=%0b want 0/0", bus.i_ready, bus.d_ready); end
    step();
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.d_ready !== 1'b0) begin errors++; $display("[TB] FAIL stab idle_state: got r=%0b w=%0b d=%0b want 0/0/0", bus.mem_read, bus.mem_write, bus.d_ready); end
    bus.mem_ready = 0;
    bus.i_read = 1; bus.i_addr = 28'h0000077;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000077) begin errors++; $display("[TB] FAIL stab next_grant: got r=%0b addr=%0h want 1/77", bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1;
    #1;
    step();
    bus.i_read = 0; bus.mem_ready = 0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.i_read = 1; bus.i_addr = 28'h0000055;
    step();
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("[TB] FAIL rstmid grant: got %0b want 1", bus.mem_read); end
    step();
    step();
    rst_n = 0;
    #1;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL rstmid async_drop: got %0b want 0", bus.mem_read); end
    bus.mem_ready = 1;
    #1;
    checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid no_ready: got %0b want 0", bus.i_ready); end
    step();
    bus.mem_ready = 0;
    rst_n = 1;
    step();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000055) begin errors++; $display("[TB] FAIL rstmid regrant: got r=%0b addr=%0h want 1/55", bus.mem_read, bus.mem_addr); end
    bus.mem_ready = 1;
    #1;
    checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid ready: got %0b want 1", bus.i_ready); end
    step();
    bus.i_read = 0; bus.mem_ready = 0;
    step();
  endtask

  // Both caches work through their own random transaction lists with random
  // gaps; memory answers with random latency and throws in stray mem_ready
  // pulses while idle. The model tracks only "who owns the port" and the
  // round-robin rule, and expects each grant to carry the owner's queue head.
  task automatic test_random();
    logic [ADDR_W-1:0] iAddrQ[$];
    logic [ADDR_W-1:0] dAddrQ[$];
    logic              dWrQ[$];
    logic [DATA_W-1:0] dDataQ[$];
    int                owner;
    int                lastSide;
    int                iGap;
    int                dGap;
    int                lat;
    logic              expWr;
    logic [ADDR_W-1:0] expAddr;
    logic [DATA_W-1:0] expWdata;
    logic [DATA_W-1:0] rdata;
    logic              reqI;
    logic              reqD;
    logic              rdyNow;
    for (int k = 0; k < 12; k++) begin
      iAddrQ.push_back(ADDR_W'($urandom));
      dAddrQ.push_back(ADDR_W'($urandom));
      dWrQ.push_back(1'($urandom_range(0, 1)));
      dDataQ.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    do_reset();
    owner = 0; lastSide = 1; lat = 0;
    expWr = 0; expAddr = '0; expWdata = '0; rdata = '0;
    iGap = $urandom_range(0, 2); dGap = $urandom_range(0, 2);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (owner == 0 && iAddrQ.size() == 0 && dAddrQ.size() == 0) break;
      // requesters
      if (!bus.i_read && iAddrQ.size() > 0) begin
        if (iGap == 0) begin bus.i_read = 1; bus.i_addr = iAddrQ[0]; end
        else iGap--;
      end
      if (!(bus.d_read || bus.d_write) && dAddrQ.size() > 0) begin
        if (dGap == 0) begin
          bus.d_read = !dWrQ[0]; bus.d_write = dWrQ[0];
          bus.d_addr = dAddrQ[0]; bus.d_wdata = dDataQ[0];
        end else dGap--;
      end
      if (owner == 1) bus.i_addr = ADDR_W'($urandom);
      if (owner == 2) begin bus.d_addr = ADDR_W'($urandom); bus.d_wdata = {$urandom, $urandom, $urandom, $urandom}; end
      // memory
      rdata = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_rdata = rdata;
      if (owner != 0) begin
        if (lat == 0) bus.mem_ready = 1;
        else begin bus.mem_ready = 0; lat--; end
      end else begin
        bus.mem_ready = ($urandom_range(0, 3) == 0);
      end
      #1;
      rdyNow = bus.mem_ready;
      checks++; if (bus.i_ready !== (owner == 1 && rdyNow) || bus.d_ready !== (owner == 2 && rdyNow)) begin errors++; $display("[TB] FAIL rand ready@%0d: got i=%0b d=%0b want %0b/%0b", cyc, bus.i_ready, bus.d_ready, owner == 1 && rdyNow, owner == 2 && rdyNow); end
      if (owner != 0 && rdyNow) begin
        checks++; if ((owner == 1 ? bus.i_rdata : bus.d_rdata) !== rdata) begin errors++; $display("[TB] FAIL rand rdata@%0d: got %0h want %0h", cyc, owner == 1 ? bus.i_rdata : bus.d_rdata, rdata); end
      end
      reqI = bus.i_read;
      reqD = bus.d_read || bus.d_write;
      step();
      // model: port ownership across this edge
      if (owner == 0) begin
        if (reqI || reqD) begin
          owner = (reqI && (!reqD || lastSide == 2)) ? 1 : 2;
          if (owner == 1) begin expWr = 0; expAddr = iAddrQ[0]; end
          else begin expWr = dWrQ[0]; expAddr = dAddrQ[0]; expWdata = dDataQ[0]; end
          lat = $urandom_range(0, 4);
        end
      end else if (rdyNow) begin
        lastSide = owner;
        if (owner == 1) begin
          void'(iAddrQ.pop_front()); bus.i_read = 0; iGap = $urandom_range(0, 2);
        end else begin
          void'(dAddrQ.pop_front()); void'(dWrQ.pop_front()); void'(dDataQ.pop_front());
          bus.d_read = 0; bus.d_write = 0; dGap = $urandom_range(0, 2);
        end
        owner = 0;
      end
      checks++; if (bus.mem_read !== (owner != 0 && !expWr) || bus.mem_write !== (owner == 2 && expWr)) begin errors++; $display("[TB] FAIL rand strobes@%0d: got r=%0b w=%0b want %0b/%0b", cyc, bus.mem_read, bus.mem_write, owner != 0 && !expWr, owner == 2 && expWr); end
      if (owner != 0) begin
        checks++; if (bus.mem_addr !== expAddr) begin errors++; $display("[TB] FAIL rand addr@%0d: got %0h want %0h", cyc, bus.mem_addr, expAddr); end
      end
      if (owner == 2 && expWr) begin
        checks++; if (bus.mem_wdata !== expWdata) begin errors++; $display("[TB] FAIL rand wdata@%0d: got %0h want %0h", cyc, bus.mem_wdata, expWdata); end
      end
    end
    checks++; if (iAddrQ.size() != 0 || dAddrQ.size() != 0) begin errors++; $display("[TB] FAIL rand drain: got %0d/%0d left want 0/0", iAddrQ.size(), dAddrQ.size()); end
    bus.mem_ready = 0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    test_reset();
    test_single_i_read();
    test_d_write();
    test_simultaneous();
    test_alternation();
    test_stability();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
